// File: rtl/cache_controller_pkg.sv
// Shared operation and state encodings for the cache transaction engine.
package ctrl_types_pkg;

    typedef enum logic [2:0] {
        OP_NOOP = 3'd0,
        OP_GET  = 3'd1,
        OP_PUT  = 3'd2,
        OP_DEL  = 3'd3
    } operation_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/cache_controller_if.sv
// Request/response and entry-memory signals between the AXI4-Lite front end,
// the key-value memory and the cache controller.
interface cache_controller_if #(
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 64,
    parameter int NUM_ENTRIES = 16
);
    import ctrl_types_pkg::*;

    operation_e               operation_in;
    logic [KEY_WIDTH-1:0]     key_in;
    logic [VALUE_WIDTH-1:0]   value_in;
    logic                     start_in;
    logic [VALUE_WIDTH-1:0]   result_value_out;
    logic [NUM_ENTRIES-1:0]   result_index_out;
    logic                     hit_out;
    logic                     err_full_out;
    logic                     done_out;
    logic [KEY_WIDTH-1:0]     mem_key_out;
    logic [VALUE_WIDTH-1:0]   mem_value_out;
    logic [NUM_ENTRIES-1:0]   mem_sel_out;
    logic                     mem_write_out;
    logic                     mem_inval_out;
    logic [NUM_ENTRIES-1:0]   mem_hit_vec_in;
    logic [NUM_ENTRIES-1:0]   mem_valid_vec_in;
    logic [VALUE_WIDTH-1:0]   mem_value_in;

    // Controller side
    modport slave (
        input  operation_in, key_in, value_in, start_in,
        output result_value_out, result_index_out, hit_out, err_full_out, done_out,
        output mem_key_out, mem_value_out, mem_sel_out, mem_write_out, mem_inval_out,
        input  mem_hit_vec_in, mem_valid_vec_in, mem_value_in
    );

    // Requester and memory side
    modport master (
        output operation_in, key_in, value_in, start_in,
        input  result_value_out, result_index_out, hit_out, err_full_out, done_out,
        input  mem_key_out, mem_value_out, mem_sel_out, mem_write_out, mem_inval_out,
        output mem_hit_vec_in, mem_valid_vec_in, mem_value_in
    );

endinterface

// File: rtl/cache_prio_enc.sv
// Lowest-set-bit extractor: one-hot of the least significant 1, zero for zero input.
module cache_prio_enc #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] vec_in,
    output logic [WIDTH-1:0] first_out
);

    // Two's complement isolates the lowest set bit.
    assign first_out = vec_in & (~vec_in + {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/cache_controller.sv
// Cache transaction engine: lookup, access and write/invalidate sequencing.
// Optional round-robin eviction on full PUT miss when CTRL_EVICT_EN is defined.
//
// state  | meaning
// IDLE   | wait for start_in, latch operation/key/value
// LOOKUP | present key, pick hit/free slot, set up memory strobes
// ACCESS | strobes active for one cycle, results captured at the edge
// DONE   | done_out pulse
module cache_controller
    import ctrl_types_pkg::*;
#(
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 64,
    parameter int NUM_ENTRIES = 16
) (
    input logic               clk,
    input logic               rst_n,
    cache_controller_if.slave bus
);

    ctrl_state_e              state;
    operation_e               op_q;
    logic [KEY_WIDTH-1:0]     key_q;
    logic [VALUE_WIDTH-1:0]   value_q;
    logic                     hit_any_q;
    logic                     full_miss_q;
    logic [NUM_ENTRIES-1:0]   mem_sel_q;
    logic                     mem_write_q;
    logic                     mem_inval_q;
    logic [VALUE_WIDTH-1:0]   result_value_q;
    logic [NUM_ENTRIES-1:0]   result_index_q;
    logic                     hit_q;
    logic                     err_full_q;
    logic                     done_q;
    logic [NUM_ENTRIES-1:0]   hit_first;
    logic [NUM_ENTRIES-1:0]   free_first;
    logic [NUM_ENTRIES-1:0]   valid_inv;
`ifdef CTRL_EVICT_EN
    logic [NUM_ENTRIES-1:0]   evict_ptr;
`endif

    assign valid_inv = ~bus.mem_valid_vec_in;

    cache_prio_enc #(.WIDTH(NUM_ENTRIES)) u_hit_enc (
        .vec_in    (bus.mem_hit_vec_in),
        .first_out (hit_first)
    );

    cache_prio_enc #(.WIDTH(NUM_ENTRIES)) u_free_enc (
        .vec_in    (valid_inv),
        .first_out (free_first)
    );

    // Strobes are registered at the LOOKUP edge so they are live exactly in ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            op_q           <= OP_NOOP;
            key_q          <= '0;
            value_q        <= '0;
            hit_any_q      <= 1'b0;
            full_miss_q    <= 1'b0;
            mem_sel_q      <= '0;
            mem_write_q    <= 1'b0;
            mem_inval_q    <= 1'b0;
            result_value_q <= '0;
            result_index_q <= '0;
            hit_q          <= 1'b0;
            err_full_q     <= 1'b0;
            done_q         <= 1'b0;
`ifdef CTRL_EVICT_EN
            evict_ptr      <= {{(NUM_ENTRIES-1){1'b0}}, 1'b1};
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_in) begin
                        op_q    <= bus.operation_in;
                        key_q   <= bus.key_in;
                        value_q <= bus.value_in;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit_any_q   <= |bus.mem_hit_vec_in;
                    full_miss_q <= 1'b0;
                    mem_sel_q   <= '0;
                    mem_write_q <= 1'b0;
                    mem_inval_q <= 1'b0;
                    case (op_q)
                        OP_GET: mem_sel_q <= hit_first;
                        OP_PUT: begin
                            if (|bus.mem_hit_vec_in) begin
                                mem_sel_q   <= hit_first;
                                mem_write_q <= 1'b1;
                            end else if (free_first != '0) begin
                                mem_sel_q   <= free_first;
                                mem_write_q <= 1'b1;
                            end else begin
`ifdef CTRL_EVICT_EN
                                mem_sel_q   <= evict_ptr;
                                mem_write_q <= 1'b1;
                                evict_ptr   <= {evict_ptr[NUM_ENTRIES-2:0], evict_ptr[NUM_ENTRIES-1]};
`else
                                full_miss_q <= 1'b1;
`endif
                            end
                        end
                        OP_DEL: begin
                            if (|bus.mem_hit_vec_in) begin
                                mem_sel_q   <= hit_first;
                                mem_inval_q <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                    state <= ACCESS;
                end
                ACCESS: begin
                    result_index_q <= mem_sel_q;
                    hit_q          <= hit_any_q;
                    err_full_q     <= full_miss_q;
                    if (op_q == OP_GET)
                        result_value_q <= hit_any_q ? bus.mem_value_in : '0;
                    mem_sel_q   <= '0;
                    mem_write_q <= 1'b0;
                    mem_inval_q <= 1'b0;
                    done_q      <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_key_out      = key_q;
    assign bus.mem_value_out    = value_q;
    assign bus.mem_sel_out      = mem_sel_q;
    assign bus.mem_write_out    = mem_write_q;
    assign bus.mem_inval_out    = mem_inval_q;
    assign bus.result_value_out = result_value_q;
    assign bus.result_index_out = result_index_q;
    assign bus.hit_out          = hit_q;
    assign bus.err_full_out     = err_full_q;
    assign bus.done_out         = done_q;

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed steps plus random ops
// compared against an array-based model of the key-value store.
module tb_cache_controller;
    import ctrl_types_pkg::*;

    localparam int KW = 16;
    localparam int VW = 64;
    localparam int NE = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_controller_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .NUM_ENTRIES(NE)) bus ();

    cache_controller #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .NUM_ENTRIES(NE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Entry memory the controller drives
    logic [KW-1:0] env_key [NE] = '{default: '0};
    logic [VW-1:0] env_val [NE] = '{default: '0};
    logic [NE-1:0] env_valid = '0;
    logic          bd_en = 1'b0;
    int            bd_idx = 0;
    logic [KW-1:0] bd_key = '0;
    logic [VW-1:0] bd_val = '0;
    logic [NE-1:0] hv;
    logic [VW-1:0] rv;

    always @(posedge clk) begin
        if (bd_en) begin
            env_key[bd_idx]   <= bd_key;
            env_val[bd_idx]   <= bd_val;
            env_valid[bd_idx] <= 1'b1;
        end
        for (int i = 0; i < NE; i++) begin
            if (bus.mem_sel_out[i] && bus.mem_write_out) begin
                env_key[i]   <= bus.mem_key_out;
                env_val[i]   <= bus.mem_value_out;
                env_valid[i] <= 1'b1;
            end
            if (bus.mem_sel_out[i] && bus.mem_inval_out)
                env_valid[i] <= 1'b0;
        end
    end

    always_comb begin
        hv = '0;
        rv = '0;
        for (int i = 0; i < NE; i++) begin
            hv[i] = env_valid[i] && (env_key[i] == bus.mem_key_out);
            if (bus.mem_sel_out[i]) rv = rv | env_val[i];
        end
    end

    assign bus.mem_hit_vec_in   = hv;
    assign bus.mem_valid_vec_in = env_valid;
    assign bus.mem_value_in     = rv;

    // Reference store
    logic [KW-1:0] ref_key [NE];
    logic [VW-1:0] ref_val [NE];
    bit            ref_valid [NE];
    int            ref_ptr;
    logic [VW-1:0] exp_rval;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem_state();
        int mism = 0;
        for (int i = 0; i < NE; i++) begin
            if (env_valid[i] !== ref_valid[i]) mism++;
            else if (ref_valid[i] && (env_key[i] !== ref_key[i] || env_val[i] !== ref_val[i])) mism++;
        end
        chk("mem_state", mism, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        logic any;
        any = (|bus.result_value_out) | (|bus.result_index_out) | bus.hit_out | bus.err_full_out |
              bus.done_out | (|bus.mem_key_out) | (|bus.mem_value_out) | (|bus.mem_sel_out) |
              bus.mem_write_out | bus.mem_inval_out;
        chk(tag, any, 0);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [KW-1:0] key,
                          input logic [VW-1:0] val, input bit noisy);
        int h = -1, f = -1, slot = -1;
        bit exp_hit, exp_err = 0, exp_wr = 0, exp_inv = 0;
        logic [NE-1:0] exp_sel = '0;
        int done_cnt = 0, done_at = 0, wr_cnt = 0, inv_cnt = 0, bad_cyc = 0;
        logic [NE-1:0] sel_c2 = '0;
        logic [KW-1:0] mkey_c2 = '0;
        logic [VW-1:0] mval_c2 = '0;
        logic hit_c3 = 0, err_c3 = 0;
        logic [NE-1:0] idx_c3 = '0;
        logic [VW-1:0] rval_c3 = '0;

        for (int i = 0; i < NE; i++) begin
            if (h < 0 && ref_valid[i] && ref_key[i] == key) h = i;
            if (f < 0 && !ref_valid[i]) f = i;
        end
        exp_hit = (h >= 0);
        case (op)
            3'd1: begin
                if (h >= 0) begin exp_sel[h] = 1'b1; exp_rval = ref_val[h]; end
                else exp_rval = '0;
            end
            3'd2: begin
                slot = (h >= 0) ? h : f;
                if (slot < 0) begin
`ifdef CTRL_EVICT_EN
                    slot = ref_ptr;
                    ref_ptr = (ref_ptr + 1) % NE;
`else
                    exp_err = 1;
`endif
                end
                if (slot >= 0) begin exp_sel[slot] = 1'b1; exp_wr = 1; end
            end
            3'd3: if (h >= 0) begin exp_sel[h] = 1'b1; exp_inv = 1; end
            default: ;
        endcase

        @(negedge clk);
        bus.operation_in = operation_e'(op);
        bus.key_in = key;
        bus.value_in = val;
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (bus.done_out) begin done_cnt++; done_at = c; end
            if (bus.mem_write_out) begin wr_cnt++; if (c != 2) bad_cyc++; end
            if (bus.mem_inval_out) begin inv_cnt++; if (c != 2) bad_cyc++; end
            if (c == 2) begin sel_c2 = bus.mem_sel_out; mkey_c2 = bus.mem_key_out; mval_c2 = bus.mem_value_out; end
            if (c == 3) begin
                hit_c3 = bus.hit_out; err_c3 = bus.err_full_out;
                idx_c3 = bus.result_index_out; rval_c3 = bus.result_value_out;
            end
            if (noisy && c <= 3) begin
                bus.start_in = 1'b1;
                bus.operation_in = operation_e'($urandom_range(0, 7));
                bus.key_in = KW'($urandom);
                bus.value_in = {$urandom, $urandom};
            end else begin
                bus.start_in = 1'b0;
            end
            @(negedge clk);
        end
        bus.start_in = 1'b0;

        chk("done_cnt", done_cnt, 1);
        chk("done_at", done_at, 3);
        chk("strobe_cycle", bad_cyc, 0);
        chk("write_cnt", wr_cnt, exp_wr);
        chk("inval_cnt", inv_cnt, exp_inv);
        chk("access_sel", sel_c2, exp_sel);
        chk("mem_key", mkey_c2, key);
        chk("mem_value", mval_c2, val);
        chk("hit", hit_c3, exp_hit);
        chk("index", idx_c3, exp_sel);
        chk("err_full", err_c3, exp_err);
        chk("result_value", rval_c3, exp_rval);

        if (exp_wr) begin ref_key[slot] = key; ref_val[slot] = val; ref_valid[slot] = 1; end
        if (exp_inv) ref_valid[h] = 0;
        chk_mem_state();
    endtask

    task automatic backdoor(input int idx, input logic [KW-1:0] k, input logic [VW-1:0] v);
        @(negedge clk);
        bd_en = 1'b1; bd_idx = idx; bd_key = k; bd_val = v;
        @(negedge clk);
        bd_en = 1'b0;
        ref_key[idx] = k; ref_val[idx] = v; ref_valid[idx] = 1;
    endtask

    initial begin
        int done_seen;
        bus.operation_in = OP_NOOP;
        bus.key_in = '0;
        bus.value_in = '0;
        bus.start_in = 1'b0;
        for (int i = 0; i < NE; i++) begin ref_key[i] = '0; ref_val[i] = '0; ref_valid[i] = 0; end
        ref_ptr = 0;
        exp_rval = '0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;

        run_op(3'd2, 16'h1234, 64'hDEADBEEF_00000001, 0);
        run_op(3'd1, 16'h1234, 64'h0, 0);
        run_op(3'd1, 16'h9999, 64'h0, 0);
        run_op(3'd2, 16'h1234, 64'h5, 0);
        run_op(3'd3, 16'h1234, 64'h0, 0);
        run_op(3'd1, 16'h1234, 64'h0, 0);
        run_op(3'd2, 16'h4321, 64'hCAFE, 0);
        run_op(3'd5, 16'h4321, 64'h77, 0);
        run_op(3'd1, 16'h4321, 64'h0, 1);
        run_op(3'd3, 16'h4321, 64'h0, 1);

        // Reset during ACCESS of a PUT
        @(negedge clk);
        bus.operation_in = OP_PUT; bus.key_in = 16'h5555; bus.value_in = 64'h1111; bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        @(negedge clk);
        chk("pre_reset_write", bus.mem_write_out, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_ptr = 0;
        exp_rval = '0;
        done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done_out || bus.mem_write_out) done_seen++;
        end
        chk("post_reset_quiet", done_seen, 0);
        chk_mem_state();

        // Fill, then overflow
        for (int i = 0; i < NE; i++) run_op(3'd2, 16'h0100 + 16'(i), {$urandom, $urandom}, 0);
        run_op(3'd2, 16'h0F00, 64'hAAAA, 0);
        run_op(3'd2, 16'h0F01, 64'hBBBB, 0);

        // Duplicate keys: lowest index wins
        backdoor(5, 16'hABCD, 64'h5050);
        backdoor(9, 16'hABCD, 64'h9090);
        run_op(3'd1, 16'hABCD, 64'h0, 0);
        run_op(3'd3, 16'hABCD, 64'h0, 0);
        run_op(3'd1, 16'hABCD, 64'h0, 0);

        for (int n = 0; n < 200; n++) begin
            logic [2:0] op;
            int r;
            r = $urandom_range(0, 9);
            op = (r < 3) ? 3'd2 : (r < 6) ? 3'd1 : (r < 8) ? 3'd3 : 3'($urandom_range(0, 7));
            run_op(op, 16'h0100 + 16'($urandom_range(0, 23)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
